// File: rtl/signmag_decoder_if.sv
// Handshake bundle between the signadder result stage and signmag_decoder.
// The master side drives the input word and downstream ready; the slave side is the decoder.
interface signmag_decoder_if #(
    parameter int bitNUmber = 8
);
    logic [bitNUmber-1:0] sm_in;
    logic                 carry_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [bitNUmber:0]   tc_out;
    logic                 ovf;
    logic                 negz;
    logic                 out_valid;
    logic                 out_ready;
    logic                 cnt_clr;
    logic [7:0]           ovf_cnt;

    modport master (
        output sm_in, carry_in, in_valid, out_ready, cnt_clr,
        input  in_ready, tc_out, ovf, negz, out_valid, ovf_cnt
    );

    modport slave (
        input  sm_in, carry_in, in_valid, out_ready, cnt_clr,
        output in_ready, tc_out, ovf, negz, out_valid, ovf_cnt
    );
endinterface

// File: rtl/signmag_decoder.sv
// Two-stage sign-magnitude to two's-complement decoder with valid/ready flow control.
// Define SIGNMAG_DECODER_SAT_EN to clamp results to the bitNUmber-bit two's-complement range.
module signmag_decoder #(
    parameter int bitNUmber = 8
) (
    input logic               clk1,
    input logic               rst,
    signmag_decoder_if.slave  bus
);
    logic [bitNUmber-1:0] r_s1_sm;
    logic                 r_s1_carry;
    logic                 r_s1_valid;

    logic [bitNUmber:0]   r_tc;
    logic                 r_ovf;
    logic                 r_negz;
    logic                 r_out_valid;
    logic [7:0]           r_ovf_cnt;

    logic                 w_out_fire;
    logic                 w_s1_adv;
    logic                 w_in_ready;
    logic                 w_in_fire;

    logic                 w_sign;
    logic [bitNUmber-1:0] w_mag;
    logic [bitNUmber:0]   w_exact;
    logic [bitNUmber:0]   w_tc;
    logic                 w_ovf;
    logic                 w_negz;

    assign w_out_fire = r_out_valid & bus.out_ready;
    assign w_s1_adv   = r_s1_valid & (~r_out_valid | bus.out_ready);
    // in_ready is deliberately combinational from out_ready so a released stall refills at once.
    assign w_in_ready = ~r_s1_valid | w_s1_adv;
    assign w_in_fire  = bus.in_valid & w_in_ready;

    assign w_sign  = r_s1_sm[bitNUmber-1];
    assign w_mag   = {r_s1_carry, r_s1_sm[bitNUmber-2:0]};
    assign w_exact = w_sign ? -{1'b0, w_mag} : {1'b0, w_mag};
    assign w_negz  = w_sign & (w_mag == '0);

`ifdef SIGNMAG_DECODER_SAT_EN
    localparam logic [bitNUmber:0]   C_POS_MAX = {2'b00, {(bitNUmber-1){1'b1}}};
    localparam logic [bitNUmber:0]   C_NEG_MIN = {2'b11, {(bitNUmber-1){1'b0}}};
    localparam logic [bitNUmber-1:0] C_NEG_LIM = {1'b1, {(bitNUmber-1){1'b0}}};

    logic w_pos_clip;
    logic w_neg_clip;

    // -2^(bitNUmber-1) itself is representable, so only magnitudes above it clip.
    assign w_pos_clip = ~w_sign & w_mag[bitNUmber-1];
    assign w_neg_clip = w_sign & (w_mag > C_NEG_LIM);

    always_comb begin
        w_tc  = w_exact;
        w_ovf = 1'b0;
        if (w_pos_clip) begin
            w_tc  = C_POS_MAX;
            w_ovf = 1'b1;
        end else if (w_neg_clip) begin
            w_tc  = C_NEG_MIN;
            w_ovf = 1'b1;
        end
    end
`else
    assign w_tc  = w_exact;
    assign w_ovf = r_s1_carry;
`endif

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sm    <= '0;
            r_s1_carry <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_sm    <= bus.sm_in;
            r_s1_carry <= bus.carry_in;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_tc        <= '0;
            r_ovf       <= 1'b0;
            r_negz      <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_tc        <= w_tc;
            r_ovf       <= w_ovf;
            r_negz      <= w_negz;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_ovf_cnt <= '0;
        end else if (w_out_fire && r_ovf && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.tc_out    = r_tc;
    assign bus.ovf       = r_ovf;
    assign bus.negz      = r_negz;
    assign bus.out_valid = r_out_valid;
    assign bus.ovf_cnt   = r_ovf_cnt;
endmodule

// File: tb/tb_signmag_decoder.sv
// Bench for signmag_decoder: directed steps plus random traffic against an arithmetic reference model.
module tb_signmag_decoder;
    localparam int N = 8;

    logic clk1 = 1'b0;
    logic rst;

    signmag_decoder_if #(.bitNUmber(N)) bus ();

    signmag_decoder #(.bitNUmber(N)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {negz, ovf, tc[N:0]} using signed integer arithmetic.
    function automatic logic [N+2:0] model(input logic [N-1:0] sm, input logic c);
        int m;
        int v;
        logic [31:0] vb;
        logic o;
        logic nz;
        m  = (c ? (1 << (N-1)) : 0) + int'(sm[N-2:0]);
        v  = sm[N-1] ? -m : m;
        o  = c;
        nz = sm[N-1] && (m == 0);
`ifdef SIGNMAG_DECODER_SAT_EN
        o = 1'b0;
        if (v > (1 << (N-1)) - 1) begin
            v = (1 << (N-1)) - 1;
            o = 1'b1;
        end else if (v < -(1 << (N-1))) begin
            v = -(1 << (N-1));
            o = 1'b1;
        end
`endif
        vb = v;
        return {nz, o, vb[N:0]};
    endfunction

    logic [N+2:0] exp_q[$];
    logic [N+2:0] e;
    int           m_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [N:0]   prev_tc = '0;
    logic         fire;
    logic         e_ovf;

    always @(negedge clk1) begin
        if (rst) begin
            exp_q.delete();
            m_cnt      = 0;
            prev_stall = 1'b0;
        end else begin
            check("ovf_cnt", {24'd0, bus.ovf_cnt}, m_cnt);
            if (prev_stall)
                check("hold_tc", {22'd0, bus.out_valid, bus.tc_out}, {22'd0, 1'b1, prev_tc});
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.sm_in, bus.carry_in));
            fire  = bus.out_valid && bus.out_ready;
            e_ovf = 1'b0;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tc_out", {23'd0, bus.tc_out}, {23'd0, e[N:0]});
                    check("ovf", {31'd0, bus.ovf}, {31'd0, e[N+1]});
                    check("negz", {31'd0, bus.negz}, {31'd0, e[N+2]});
                    e_ovf = e[N+1];
                end
            end
            if (bus.cnt_clr) m_cnt = 0;
            else if (fire && e_ovf && m_cnt < 255) m_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_tc    = bus.tc_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic one_word(input logic [N-1:0] sm, input logic c, input logic [N:0] x_tc,
                            input logic x_ovf, input logic x_negz, input string tag);
        @(posedge clk1); #1;
        bus.in_valid = 1'b1;
        bus.sm_in    = sm;
        bus.carry_in = c;
        @(negedge clk1);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk1); #1;
        bus.in_valid = 1'b0;
        @(negedge clk1);
        check({tag, "_lat_early"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk1);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_tc"}, {23'd0, bus.tc_out}, {23'd0, x_tc});
        check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, x_ovf});
        check({tag, "_negz"}, {31'd0, bus.negz}, {31'd0, x_negz});
    endtask

    task automatic drain();
        @(posedge clk1); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk1);
    endtask

    logic [N-1:0] bp_sm[4];
    logic         bp_c[4];
    int           idx;
    int           acc;
    logic         seen;

    initial begin
        rst          = 1'b1;
        bus.sm_in    = '0;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.cnt_clr  = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_tc", {23'd0, bus.tc_out}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_negz", {31'd0, bus.negz}, 32'd0);
        check("rst_cnt", {24'd0, bus.ovf_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        one_word(8'h05, 1'b0, 9'h005, 1'b0, 1'b0, "pos5");
        one_word(8'h85, 1'b0, 9'h1FB, 1'b0, 1'b0, "neg5");
        one_word(8'h80, 1'b0, 9'h000, 1'b0, 1'b1, "negzero");
        one_word(8'h00, 1'b0, 9'h000, 1'b0, 1'b0, "poszero");
`ifdef SIGNMAG_DECODER_SAT_EN
        one_word(8'h7F, 1'b1, 9'h07F, 1'b1, 1'b0, "sat_pos");
        one_word(8'hFF, 1'b1, 9'h180, 1'b1, 1'b0, "sat_neg");
        one_word(8'h80, 1'b1, 9'h180, 1'b0, 1'b0, "sat_min");
        repeat (3) @(negedge clk1);
        check("ovf_cnt_trio", {24'd0, bus.ovf_cnt}, 32'd2);
`else
        one_word(8'h7F, 1'b1, 9'h0FF, 1'b1, 1'b0, "ovf_pos");
        one_word(8'hFF, 1'b1, 9'h101, 1'b1, 1'b0, "ovf_neg");
        one_word(8'h80, 1'b1, 9'h180, 1'b1, 1'b0, "ovf_min");
        repeat (3) @(negedge clk1);
        check("ovf_cnt_trio", {24'd0, bus.ovf_cnt}, 32'd3);
`endif

        // Backpressure: four words offered against a stalled sink.
        bp_sm[0] = 8'h11; bp_c[0] = 1'b0;
        bp_sm[1] = 8'h92; bp_c[1] = 1'b0;
        bp_sm[2] = 8'h23; bp_c[2] = 1'b1;
        bp_sm[3] = 8'hA4; bp_c[3] = 1'b0;
        @(posedge clk1); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        idx = 0;
        acc = 0;
        bus.sm_in    = bp_sm[0];
        bus.carry_in = bp_c[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk1);
            if (acc >= 2) begin
                check("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
            end else if (bus.in_ready) begin
                acc++;
                idx++;
            end
            @(posedge clk1); #1;
            bus.sm_in    = bp_sm[idx];
            bus.carry_in = bp_c[idx];
        end
        check("bp_accepted", acc, 32'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk1);
            check("bp_no_gap", {31'd0, bus.out_valid}, 32'd1);
            if (k == 0) check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk1); #1;
            if (idx < 4) begin
                bus.sm_in    = bp_sm[idx];
                bus.carry_in = bp_c[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("bp_all_sent", idx, 32'd4);
        drain();

        // Random traffic with random backpressure.
        bus.in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!bus.in_valid || seen) begin
                bus.in_valid = 1'($urandom_range(0, 3) != 0);
                bus.sm_in    = N'($urandom);
                bus.carry_in = 1'($urandom_range(0, 1));
            end
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            @(negedge clk1);
            seen = bus.in_valid && bus.in_ready;
            @(posedge clk1); #1;
        end
        drain();
        check("rand_drained", exp_q.size(), 32'd0);

        // Counter saturation with a stream of overflowing words.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            bus.sm_in    = {1'b0, 7'($urandom)};
            bus.carry_in = 1'b1;
            @(posedge clk1); #1;
        end
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk1);
        check("cnt_saturated", {24'd0, bus.ovf_cnt}, 32'd255);

        // Clear coincident with an overflow transfer.
        @(posedge clk1); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sm_in     = 8'h7F;
        bus.carry_in  = 1'b1;
        @(posedge clk1); #1;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk1);
            seen = bus.out_valid;
        end
        check("clr_wait_valid", {31'd0, seen}, 32'd1);
        @(posedge clk1); #1;
        bus.cnt_clr   = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk1); #1;
        bus.cnt_clr = 1'b0;
        @(negedge clk1);
        check("cnt_clr_wins", {24'd0, bus.ovf_cnt}, 32'd0);

        // Reset with two words in flight.
        @(posedge clk1); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sm_in     = 8'h33;
        bus.carry_in  = 1'b0;
        @(posedge clk1); #1;
        bus.sm_in = 8'hC4;
        @(posedge clk1); #1;
        bus.in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_async_tc", {23'd0, bus.tc_out}, 32'd0);
        check("rst_async_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk1); #3;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk1);
            check("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end

        one_word(8'h8A, 1'b0, 9'h1F6, 1'b0, 1'b0, "post_rst_word");
        drain();
        check("final_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
